// File: rtl/mems_scan_sequencer_if.sv
// SPI-master side of the MEMS scan sequencer: issue pulse, command-ROM address, busy return.
interface mems_scan_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 16
) ();
  logic                  mems_SPI_start;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  mems_SPI_busy;

  modport master (
    output mems_SPI_start,
    output addr,
    input  mems_SPI_busy
  );

  modport slave (
    input  mems_SPI_start,
    input  addr,
    output mems_SPI_busy
  );
endinterface

// File: rtl/mems_scan_sequencer.sv
// MEMS DAC command sequencer: issues the init ROM block, then walks the points x lines x frames
// scan table in wrap, triangle or one-shot order, raising sticky line/frame markers.
module mems_scan_sequencer #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned INIT_CMDS  = 2,
  parameter int unsigned SCAN_BASE  = 8,
  parameter int unsigned PPL        = 720,
  parameter int unsigned LPF        = 3,
  parameter int unsigned FPS        = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pause,
  mems_scan_sequencer_if.master        spi,
  input  logic                         mems_soft_reset,
  input  logic                         mode_oneshot,
  input  logic                         mode_bidir,
  input  logic                         new_line_FIFO_done,
  input  logic                         new_frame_FIFO_done,
  output logic                         new_line,
  output logic                         new_frame,
  output logic [15:0]                  line_idx,
  output logic [15:0]                  frame_idx,
  output logic                         scan_done,
  output logic                         marker_overrun
);

  localparam int unsigned PtW = $clog2(PPL);
  localparam logic [63:0] LastAddr = 64'(SCAN_BASE) + 64'(PPL) * 64'(LPF) * 64'(FPS) - 64'd1;

  if (LastAddr >= (64'd1 << ADDR_WIDTH)) begin : gen_addr_range_err
    $error("mems_scan_sequencer: scan table exceeds ADDR_WIDTH");
  end
  if (INIT_CMDS < 1 || SCAN_BASE < INIT_CMDS || PPL < 2 || LPF < 1 || FPS < 1)
  begin : gen_param_err
    $error("mems_scan_sequencer: illegal table geometry");
  end

  localparam logic [PtW-1:0]        PtLast   = PtW'(PPL - 1);
  localparam logic [15:0]           LnLast   = 16'(LPF - 1);
  localparam logic [15:0]           FrLast   = 16'(FPS - 1);
  localparam logic [ADDR_WIDTH-1:0] InitLast = ADDR_WIDTH'(INIT_CMDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ScanBase = ADDR_WIDTH'(SCAN_BASE);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StInit = 2'd1;
  localparam logic [1:0] StScan = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  start_q, start_d;
  logic [PtW-1:0]        point_q, point_d;
  logic [15:0]           line_q, line_d;
  logic [15:0]           frame_q, frame_d;
  logic                  dir_q, dir_d;  // 1 = reverse traversal
  logic                  pending_q, pending_d;
  logic                  scan_done_q, scan_done_d;
  logic                  nl_q, nl_d;
  logic                  nf_q, nf_d;
  logic                  ovr_q, ovr_d;

  logic opp, at_end, restart, abort, step, set_line, set_frame;

  // A start in flight blocks the next issue, so starts never land on adjacent cycles.
  assign opp = !spi.mems_SPI_busy && !start_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    start_d     = 1'b0;
    point_d     = point_q;
    line_d      = line_q;
    frame_d     = frame_q;
    dir_d       = dir_q;
    pending_d   = pending_q;
    scan_done_d = scan_done_q;
    restart     = 1'b0;
    abort       = 1'b0;
    step        = 1'b0;
    set_line    = 1'b0;
    set_frame   = 1'b0;
    at_end      = dir_q ? (point_q == '0 && line_q == '0 && frame_q == '0)
                        : (point_q == PtLast && line_q == LnLast && frame_q == FrLast);

    case (state_q)
      StIdle, StDone: begin
        restart   = (mems_soft_reset || pending_q) && opp;
        pending_d = (mems_soft_reset || pending_q) && !opp;
      end
      StInit, StScan: begin
        if (mems_soft_reset) begin
          abort     = 1'b1;
          restart   = opp;
          pending_d = !opp;
          if (!opp) state_d = StIdle;
        end else if (opp && (state_q == StInit || !pause)) begin
          step = 1'b1;
        end
      end
      default: ;
    endcase

    if (restart) begin
      state_d     = StInit;
      addr_d      = '0;
      start_d     = 1'b1;
      scan_done_d = 1'b0;
    end

    if (step) begin
      if (state_q == StInit) begin
        start_d = 1'b1;
        if (addr_q == InitLast) begin
          addr_d  = ScanBase;
          point_d = '0;
          line_d  = '0;
          frame_d = '0;
          dir_d   = 1'b0;
          state_d = StScan;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end else if (at_end && mode_oneshot) begin
        state_d     = StDone;
        scan_done_d = 1'b1;
      end else begin
        start_d = 1'b1;
        if (at_end && !mode_bidir) begin
          addr_d  = ScanBase;
          point_d = '0;
          line_d  = '0;
          frame_d = '0;
          dir_d   = 1'b0;
        end else begin
          // At a triangle turn the endpoint is not repeated: flip, then step once.
          dir_d = at_end ? !dir_q : dir_q;
          if (!dir_d) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (point_q == PtLast) begin
              point_d = '0;
              if (line_q == LnLast) begin
                line_d  = '0;
                frame_d = frame_q + 16'd1;
              end else begin
                line_d = line_q + 16'd1;
              end
            end else begin
              point_d = point_q + PtW'(1);
            end
          end else begin
            addr_d = addr_q - ADDR_WIDTH'(1);
            if (point_q == '0) begin
              point_d = PtLast;
              if (line_q == '0) begin
                line_d  = LnLast;
                frame_d = frame_q - 16'd1;
              end else begin
                line_d = line_q - 16'd1;
              end
            end else begin
              point_d = point_q - PtW'(1);
            end
          end
        end
        if (dir_d ? (point_d == '0) : (point_d == PtLast)) begin
          if (dir_d ? (line_d == '0) : (line_d == LnLast)) set_frame = 1'b1;
          else                                              set_line  = 1'b1;
        end
      end
    end

    // Clear first so a coincident set wins.
    nl_d  = nl_q & ~new_line_FIFO_done;
    nf_d  = nf_q & ~new_frame_FIFO_done;
    ovr_d = ovr_q;
    if (abort || restart) ovr_d = 1'b0;
    if (abort) begin
      nl_d = 1'b0;
      nf_d = 1'b0;
    end
    if (set_line) begin
      if (nl_q) ovr_d = 1'b1;
      nl_d = 1'b1;
    end
    if (set_frame) begin
      if (nf_q) ovr_d = 1'b1;
      nf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      start_q     <= 1'b0;
      point_q     <= '0;
      line_q      <= '0;
      frame_q     <= '0;
      dir_q       <= 1'b0;
      pending_q   <= 1'b0;
      scan_done_q <= 1'b0;
      nl_q        <= 1'b0;
      nf_q        <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      start_q     <= start_d;
      point_q     <= point_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
      dir_q       <= dir_d;
      pending_q   <= pending_d;
      scan_done_q <= scan_done_d;
      nl_q        <= nl_d;
      nf_q        <= nf_d;
      ovr_q       <= ovr_d;
    end
  end

  assign spi.mems_SPI_start = start_q;
  assign spi.addr           = addr_q;
  assign new_line           = nl_q;
  assign new_frame          = nf_q;
  assign line_idx           = line_q;
  assign frame_idx          = frame_q;
  assign scan_done          = scan_done_q;
  assign marker_overrun     = ovr_q;

endmodule

// File: tb/tb_mems_scan_sequencer.sv
// Scoreboard bench for mems_scan_sequencer: a linear-index table model predicts every issued
// start (address, indices, markers); a negedge monitor pops and compares on each start pulse.
module tb_mems_scan_sequencer;

  localparam int unsigned AW = 16;
  localparam int IC   = 2;
  localparam int SB   = 8;
  localparam int PPL  = 4;
  localparam int LPF  = 2;
  localparam int FPS  = 2;
  localparam int NPTS = PPL * LPF * FPS;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pause = 1'b0;
  logic        mems_soft_reset = 1'b0;
  logic        mode_oneshot = 1'b0;
  logic        mode_bidir = 1'b0;
  logic        ack_pulse = 1'b0;
  logic        ack_cont = 1'b0;
  logic        hold_pause = 1'b0;
  logic        rand_pause = 1'b0;
  logic        new_line, new_frame, scan_done, marker_overrun;
  logic [15:0] line_idx, frame_idx;
  int unsigned busy_cnt;

  mems_scan_sequencer_if #(.ADDR_WIDTH(AW)) spi ();

  mems_scan_sequencer #(
    .ADDR_WIDTH(AW), .INIT_CMDS(IC), .SCAN_BASE(SB), .PPL(PPL), .LPF(LPF), .FPS(FPS)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pause               (pause),
    .spi                 (spi),
    .mems_soft_reset     (mems_soft_reset),
    .mode_oneshot        (mode_oneshot),
    .mode_bidir          (mode_bidir),
    .new_line_FIFO_done  (ack_pulse | ack_cont),
    .new_frame_FIFO_done (ack_pulse | ack_cont),
    .new_line            (new_line),
    .new_frame           (new_frame),
    .line_idx            (line_idx),
    .frame_idx           (frame_idx),
    .scan_done           (scan_done),
    .marker_overrun      (marker_overrun)
  );

  always #5 clk = ~clk;

  // SPI master: busy for 3 cycles after each start.
  always @(posedge clk) begin
    if (!rst)                    busy_cnt <= 0;
    else if (spi.mems_SPI_start) busy_cnt <= 3;
    else if (busy_cnt != 0)      busy_cnt <= busy_cnt - 1;
  end
  assign spi.mems_SPI_busy = (busy_cnt != 0);

  typedef struct {
    logic [15:0] addr;
    logic [15:0] line;
    logic [15:0] frame;
    bit          chk_idx;
    bit          nl;
    bit          nf;
    bit          ovr;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;
  bit   prev_start = 1'b0;

  // Reference model state: linear table index, direction, marker flags.
  int   k = -1;
  bit   rev = 1'b0;
  bit   fl_l = 1'b0, fl_f = 1'b0, m_ovr = 1'b0;
  int   ack_mode = 0;  // 0 pulse after each start, 1 never, 2 held high
  int   last_addr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vecs++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic push(input int kk, input bit is_scan, input bit el, input bit ef);
    exp_t e;
    e.addr    = is_scan ? 16'(SB + kk) : 16'(kk);
    e.chk_idx = is_scan;
    e.line    = 16'((kk / PPL) % LPF);
    e.frame   = 16'(kk / (PPL * LPF));
    if (ack_mode == 1) begin
      m_ovr = m_ovr | (el & fl_l) | (ef & fl_f);
      fl_l  = fl_l | el;
      fl_f  = fl_f | ef;
      e.nl  = fl_l;
      e.nf  = fl_f;
    end else begin
      e.nl = el;
      e.nf = ef;
    end
    e.ovr     = m_ovr;
    last_addr = int'(e.addr);
    q.push_back(e);
  endtask

  task automatic model_restart();
    fl_l  = 1'b0;
    fl_f  = 1'b0;
    m_ovr = 1'b0;
    for (int i = 0; i < IC; i++) push(i, 1'b0, 1'b0, 1'b0);
    k   = -1;
    rev = 1'b0;
  endtask

  task automatic gen_one(input bit oneshot, input bit bidir, output bit ended);
    int  p, l;
    bit  last_pt, last_ln;
    ended = 1'b0;
    if (k < 0) begin
      k   = 0;
      rev = 1'b0;
    end else if (rev ? (k == 0) : (k == NPTS - 1)) begin
      if (oneshot) begin
        ended = 1'b1;
        return;
      end
      if (!bidir) begin
        k   = 0;
        rev = 1'b0;
      end else begin
        rev = !rev;
        k   = rev ? k - 1 : k + 1;
      end
    end else begin
      k = rev ? k - 1 : k + 1;
    end
    p       = k % PPL;
    l       = (k / PPL) % LPF;
    last_pt = rev ? (p == 0) : (p == PPL - 1);
    last_ln = rev ? (l == 0) : (l == LPF - 1);
    push(k, 1'b1, last_pt && !last_ln, last_pt && last_ln);
  endtask

  task automatic gen_n(input int n, input bit oneshot, input bit bidir);
    bit ended;
    for (int i = 0; i < n; i++) begin
      gen_one(oneshot, bidir, ended);
      if (ended) break;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
    q.delete();
    #1;
  endtask

  task automatic pulse_soft();
    mems_soft_reset = 1'b1;
    @(posedge clk);
    #1 mems_soft_reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"},  32'(spi.addr), 32'd0);
    chk({tag, "_start"}, 32'(spi.mems_SPI_start), 32'd0);
    chk({tag, "_nl"},    32'(new_line), 32'd0);
    chk({tag, "_nf"},    32'(new_frame), 32'd0);
    chk({tag, "_line"},  32'(line_idx), 32'd0);
    chk({tag, "_frame"}, 32'(frame_idx), 32'd0);
    chk({tag, "_done"},  32'(scan_done), 32'd0);
    chk({tag, "_ovr"},   32'(marker_overrun), 32'd0);
  endtask

  // Monitor: every start pulse must match the head of the scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    if (spi.mems_SPI_start === 1'b1) begin
      chk("start_gap", 32'(prev_start), 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_start", 32'(spi.addr), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("addr",      32'(spi.addr), 32'(e.addr));
        chk("new_line",  32'(new_line), 32'(e.nl));
        chk("new_frame", 32'(new_frame), 32'(e.nf));
        chk("overrun",   32'(marker_overrun), 32'(e.ovr));
        chk("scan_done", 32'(scan_done), 32'd0);
        if (e.chk_idx) begin
          chk("line_idx",  32'(line_idx), 32'(e.line));
          chk("frame_idx", 32'(frame_idx), 32'(e.frame));
        end
      end
    end
    prev_start <= spi.mems_SPI_start;
  end

  // FIFO acknowledge: one-cycle pulse two cycles after each start.
  initial begin
    forever begin
      @(negedge clk);
      if (spi.mems_SPI_start === 1'b1 && ack_mode == 0) begin
        @(posedge clk);
        @(posedge clk);
        #1 ack_pulse = 1'b1;
        @(posedge clk);
        #1 ack_pulse = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2 pause = hold_pause | (rand_pause && ($urandom_range(0, 3) == 0));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst        = 1'b1;
    rand_pause = 1'b1;
    @(posedge clk);
    #1;

    // Init then forward walk, ending on addr 10 (19 scan points).
    model_restart();
    gen_n(19, 1'b0, 1'b0);
    pulse_soft();
    drain(2000);

    // Long pause mid-line: nothing issues and addr holds.
    hold_pause = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("pause_addr",  32'(spi.addr), 32'd10);
    chk("pause_start", 32'(spi.mems_SPI_start), 32'd0);

    // Acknowledge held high: a set in the same cycle as a clear must win.
    ack_mode = 2;
    ack_cont = 1'b1;
    gen_n(16, 1'b0, 1'b0);
    hold_pause = 1'b0;
    drain(2000);

    // Triangle scan across both turn points.
    ack_mode   = 0;
    ack_cont   = 1'b0;
    mode_bidir = 1'b1;
    gen_n(40, 1'b0, 1'b1);
    drain(3000);

    // Never acknowledge: flags pile up and overrun latches; stop on addr 13.
    ack_mode   = 1;
    mode_bidir = 1'b0;
    begin
      int cnt = 0;
      bit ended;
      while (cnt < 100 && !(cnt >= 20 && last_addr == 13)) begin
        gen_one(1'b0, 1'b0, ended);
        cnt++;
      end
    end
    drain(3000);
    chk("overrun_latched", 32'(marker_overrun), 32'd1);

    // Abort at addr 13, restart into a one-shot scan.
    ack_mode     = 0;
    mode_oneshot = 1'b1;
    model_restart();
    gen_n(100, 1'b1, 1'b0);
    pulse_soft();
    chk("abort_nl",  32'(new_line), 32'd0);
    chk("abort_nf",  32'(new_frame), 32'd0);
    chk("abort_ovr", 32'(marker_overrun), 32'd0);
    drain(3000);
    rand_pause = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("oneshot_done",  32'(scan_done), 32'd1);
    chk("oneshot_addr",  32'(spi.addr), 32'(SB + NPTS - 1));
    chk("oneshot_start", 32'(spi.mems_SPI_start), 32'd0);
    rand_pause = 1'b1;

    // Restart out of DONE.
    mode_oneshot = 1'b0;
    model_restart();
    gen_n(6, 1'b0, 1'b0);
    pulse_soft();
    drain(2000);

    // Synchronous reset while the SPI master is busy.
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero("midreset");
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mems_scan_sequencer.md
Name: mems_scan_sequencer

Overview:
- Parametrised next-generation MEMS DAC command sequencer.
- Drives the MEMS SPI master with a command-ROM address and a one-cycle start pulse.
- Runs a configurable init sequence, then walks a points × lines × frames scan table.
- Raises sticky line/frame markers for the FIFO/readout path, and adds one-shot and bidirectional (triangle) scan modes plus marker-overrun detection.

Parameters:
- ADDR_WIDTH, 16, width of addr.
- INIT_CMDS, 2, number of init commands at ROM addresses 0..INIT_CMDS-1 (minimum 1).
- SCAN_BASE, 8, ROM address of the first scan point (must be ≥ INIT_CMDS).
- PPL, 720, points per line (minimum 2).
- LPF, 3, lines per frame (minimum 1).
- FPS, 2, frames per scan (minimum 1).
- Elaboration error if SCAN_BASE+PPL*LPF*FPS-1 ≥ 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- pause  in  1  1 = no new issues.
- mems_SPI_busy  in  1  SPI master busy.
- mems_soft_reset  in  1  start or restart the sequence.
- mode_oneshot  in  1  1 = stop after one scan; sampled per issue.
- mode_bidir  in  1  1 = triangle scan; sampled at scan end.
- new_line_FIFO_done  in  1  clears new_line.
- new_frame_FIFO_done  in  1  clears new_frame.
- mems_SPI_start  out  1  one-cycle issue pulse.
- addr  out  ADDR_WIDTH  ROM address, valid with mems_SPI_start and held until the next issue.
- new_line  out  1  sticky line marker.
- new_frame  out  1  sticky frame marker.
- line_idx  out  16  line of the presented point.
- frame_idx  out  16  frame of the presented point.
- scan_done  out  1  one-shot scan finished.
- marker_overrun  out  1  sticky error.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; addr, mems_SPI_start, new_line, new_frame, line_idx, frame_idx, scan_done, marker_overrun all 0; direction forward. All outputs are registered.
- Issue opportunity: mems_SPI_busy=0 and mems_SPI_start=0 in the current cycle. Consecutive starts are therefore separated by at least one idle cycle.
- An issue registers mems_SPI_start=1 together with the new addr on the next edge (latency 1).
- States are IDLE, INIT, SCAN, DONE.
- IDLE:
  - addr held at 0.
  - On mems_soft_reset=1 at an issue opportunity: issue addr 0, go to INIT.
  - If not at an issue opportunity, wait in IDLE with a pending-restart flag.
- INIT:
  - Each issue presents addr+1 until addr = INIT_CMDS-1.
  - The next issue presents SCAN_BASE with point/line/frame indices all 0, direction forward, and enters SCAN.
  - pause is ignored in INIT.
- SCAN:
  - Issue only when pause=0.
  - Forward issue: addr+1 and point index +1, carrying into line_idx and frame_idx.
  - Reverse issue: addr-1 and point index -1, borrowing.
- Markers:
  - A marker event occurs when the newly presented point is the last of its line in traversal order: point PPL-1 going forward, point 0 going reverse.
  - If that point is also the last line of its frame in traversal order, new_frame is set instead of new_line. Frame supersedes line; the two are never set by the same event.
  - The marker rises in the same cycle as that point's mems_SPI_start.
- End of scan (final point in traversal order has been presented; the next issue decides):
  - mode_oneshot=1: no issue; enter DONE, scan_done=1.
  - mode_bidir=0: present SCAN_BASE, indices reset to 0, direction forward.
  - mode_bidir=1: reverse direction and present the adjacent point. The endpoint is not repeated.
- DONE: no issues; addr held. mems_soft_reset → restart as in IDLE, with scan_done cleared on the restart issue.
- Marker clearing: a FIFO_done pulse clears its flag next cycle. If a set event and a clear occur in the same cycle, the set wins.
- Overrun: a set event while the target flag is already 1 sets marker_overrun. It stays 1 until rst or a soft-reset restart.
- mems_soft_reset in INIT or SCAN:
  - Abort immediately: no further scan issues, markers cleared, marker_overrun cleared.
  - Then restart via the IDLE rule at the next issue opportunity.
  - A start already in flight is not cancelled.
- Reset mid-operation returns all registers to their reset values on that edge regardless of state.

Test Plan:
- Common parameters: PPL=4, LPF=2, FPS=2, INIT_CMDS=2, SCAN_BASE=8; SPI model with busy for 3 cycles after each start.
- Init: rst deassert, soft_reset pulse → starts with addr 0, 1, 8, 9…; no two starts in adjacent cycles; scan_done=0.
- Forward loop: free-run, FIFO_done pulsed 2 cycles after each marker → new_line at addr 11, 19; new_frame at 15, 23; after 23, addr wraps to 8; marker_overrun=0.
- Bidir/oneshot:
  - mode_bidir=1: sequence is …22, 23, 22, …, 8, 9…; new_frame at 23, 16 and 8; new_line at 20 and 12.
  - mode_oneshot=1: after 23, no further starts; scan_done=1; soft_reset → addr 0 issued, scan_done=0.
- Pause: hold pause=1 for 20 cycles mid-line at addr 10 → no starts, addr stays 10; the resume issue is addr 11.
- Overrun and collision:
  - Never pulse FIFO_done → marker_overrun=1 at addr 19.
  - FIFO_done coincident with a set event → flag stays 1.
- Abort and reset:
  - soft_reset at addr 13 → markers cleared, next start addr 0.
  - rst=0 during busy → all outputs 0 next edge.
